// File: rtl/tluh_32_pkg.sv
// TL-UL (32-bit data, 8-bit source) channel payloads and opcodes.
package tluh_32_pkg;

   localparam logic [2:0] OpPutFullData    = 3'h0;
   localparam logic [2:0] OpPutPartialData = 3'h1;
   localparam logic [2:0] OpGet            = 3'h4;
   localparam logic [2:0] OpAccessAck      = 3'h0;
   localparam logic [2:0] OpAccessAckData  = 3'h1;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

endpackage

// File: rtl/spi_host_window_initiator.sv
// TL-UL initiator moving a TX word stream into the SPI host TX window and RX window reads into a local stream.
// Optional response counters are built when SPI_HOST_WIN_INIT_PERF_EN is defined.
module spi_host_window_initiator
   import tluh_32_pkg::*;
#(
   parameter logic [31:0] TxAddr = 32'h0000_0024,
   parameter logic [31:0] RxAddr = 32'h0000_0028,
   parameter int unsigned MaxOut = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output tl_h2d_t     tl_o,
   input  tl_d2h_t     tl_i,
   input  logic [31:0] tx_data_i,
   input  logic [3:0]  tx_be_i,
   input  logic        tx_valid_i,
   output logic        tx_ready_o,
   input  logic        rx_en_i,
   output logic [31:0] rx_data_o,
   output logic        rx_err_o,
   output logic        rx_valid_o,
   input  logic        rx_ready_i,
   output logic        err_o,
   output logic        busy_o,
   output logic [15:0] wr_cnt_o,
   output logic [15:0] rd_cnt_o
);

   localparam int unsigned CntW = $clog2(MaxOut + 1);
   localparam int unsigned SumW = CntW + 1;
   localparam int unsigned PtrW = (MaxOut > 1) ? $clog2(MaxOut) : 1;
   localparam logic [SumW-1:0] MaxOutS = SumW'(MaxOut);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOut - 1);

   logic            a_full_q;
   logic            a_read_q;
   logic [2:0]      a_opcode_q;
   logic [31:0]     a_addr_q;
   logic [3:0]      a_mask_q;
   logic [31:0]     a_data_q;
   logic            last_tx_q;
   logic [CntW-1:0] outst_q;
   logic [CntW-1:0] rd_flight_q;
   logic [CntW-1:0] rx_fill_q;
   logic [PtrW-1:0] rx_wr_ptr_q;
   logic [PtrW-1:0] rx_rd_ptr_q;
   logic [31:0]     rx_mem_q [MaxOut];
   logic            rx_err_mem_q [MaxOut];
   logic            err_q;

   logic a_fire, d_ok, d_rd, d_wr, a_loadable, credit, rx_ok, load_tx, load_rx;
   logic rx_push, rx_pop;
   logic unused_tl;

   // Issue decision: credit and RX-buffer reservation, then round-robin between TX and RX
   always_comb begin
      a_fire     = a_full_q & tl_i.a_ready;
      d_ok       = tl_i.d_valid & (outst_q != '0);
      d_rd       = d_ok & tl_i.d_source[0];
      d_wr       = d_ok & ~tl_i.d_source[0];
      a_loadable = ~a_full_q | a_fire;
      credit     = ({1'b0, outst_q} + SumW'(a_full_q)) < MaxOutS;
      rx_ok      = rx_en_i & (({1'b0, rx_fill_q} + {1'b0, rd_flight_q}) < MaxOutS);
      tx_ready_o = credit & a_loadable & ~(rx_ok & last_tx_q);
      load_tx    = tx_valid_i & tx_ready_o;
      load_rx    = ~load_tx & rx_ok & credit & a_loadable;
      rx_push    = d_rd;
      rx_pop     = rx_valid_o & rx_ready_i;
   end

   always_comb begin
      tl_o           = '0;
      tl_o.a_valid   = a_full_q;
      tl_o.a_opcode  = a_opcode_q;
      tl_o.a_size    = 2'd2;
      tl_o.a_source  = {7'd0, a_read_q};
      tl_o.a_address = a_addr_q;
      tl_o.a_mask    = a_mask_q;
      tl_o.a_data    = a_data_q;
      tl_o.d_ready   = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_full_q    <= 1'b0;
         a_read_q    <= 1'b0;
         a_opcode_q  <= '0;
         a_addr_q    <= '0;
         a_mask_q    <= '0;
         a_data_q    <= '0;
         last_tx_q   <= 1'b0;
         outst_q     <= '0;
         rd_flight_q <= '0;
         rx_fill_q   <= '0;
         rx_wr_ptr_q <= '0;
         rx_rd_ptr_q <= '0;
         err_q       <= 1'b0;
         for (int i = 0; i < int'(MaxOut); i++) begin
            rx_mem_q[i]     <= '0;
            rx_err_mem_q[i] <= 1'b0;
         end
      end else begin
         if (load_tx || load_rx) begin
            a_full_q   <= 1'b1;
            a_read_q   <= load_rx;
            a_opcode_q <= load_rx ? OpGet :
                          ((tx_be_i == 4'hF) ? OpPutFullData : OpPutPartialData);
            a_addr_q   <= load_rx ? RxAddr : TxAddr;
            a_mask_q   <= load_rx ? 4'hF : tx_be_i;
            a_data_q   <= load_rx ? 32'd0 : tx_data_i;
            last_tx_q  <= load_tx;
         end else if (a_fire) begin
            a_full_q <= 1'b0;
         end

         case ({a_fire, d_ok})
            2'b10:   outst_q <= outst_q + CntW'(1);
            2'b01:   outst_q <= outst_q - CntW'(1);
            default: outst_q <= outst_q;
         endcase

         case ({load_rx, d_rd})
            2'b10:   rd_flight_q <= rd_flight_q + CntW'(1);
            2'b01:   rd_flight_q <= rd_flight_q - CntW'(1);
            default: rd_flight_q <= rd_flight_q;
         endcase

         // Errored reads still occupy a slot so the consumer sees the error in order
         if (rx_push) begin
            rx_mem_q[rx_wr_ptr_q]     <= tl_i.d_error ? 32'd0 : tl_i.d_data;
            rx_err_mem_q[rx_wr_ptr_q] <= tl_i.d_error;
            rx_wr_ptr_q <= (rx_wr_ptr_q == LastPtr) ? '0 : rx_wr_ptr_q + PtrW'(1);
         end
         if (rx_pop) begin
            rx_rd_ptr_q <= (rx_rd_ptr_q == LastPtr) ? '0 : rx_rd_ptr_q + PtrW'(1);
         end
         case ({rx_push, rx_pop})
            2'b10:   rx_fill_q <= rx_fill_q + CntW'(1);
            2'b01:   rx_fill_q <= rx_fill_q - CntW'(1);
            default: rx_fill_q <= rx_fill_q;
         endcase

         // Stray responses (nothing outstanding) are dropped but flagged
         err_q <= tl_i.d_valid & (~d_ok | tl_i.d_error);
      end
   end

   assign rx_valid_o = (rx_fill_q != '0);
   assign rx_data_o  = rx_mem_q[rx_rd_ptr_q];
   assign rx_err_o   = rx_err_mem_q[rx_rd_ptr_q];
   assign err_o      = err_q;
   assign busy_o     = a_full_q | (outst_q != '0);

`ifdef SPI_HOST_WIN_INIT_PERF_EN
   logic [15:0] wr_cnt_q;
   logic [15:0] rd_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else begin
         if (d_wr) wr_cnt_q <= wr_cnt_q + 16'd1;
         if (d_rd) rd_cnt_q <= rd_cnt_q + 16'd1;
      end
   end

   assign wr_cnt_o = wr_cnt_q;
   assign rd_cnt_o = rd_cnt_q;
`else
   assign wr_cnt_o = 16'd0;
   assign rd_cnt_o = 16'd0;
`endif

   assign unused_tl = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source[7:1],
                        tl_i.d_sink, d_wr};

endmodule

// File: tb/tb_spi_host_window_initiator.sv
// Directed self-checking bench for spi_host_window_initiator with a simple in-order TL-UL device model.
module tb_spi_host_window_initiator;
   import tluh_32_pkg::*;

`ifdef SPI_HOST_WIN_INIT_PERF_EN
   localparam bit PerfEn = 1'b1;
`else
   localparam bit PerfEn = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i;
   tl_h2d_t     tl_o;
   tl_d2h_t     tl_i;
   logic [31:0] tx_data_i;
   logic [3:0]  tx_be_i;
   logic        tx_valid_i;
   logic        tx_ready_o;
   logic        rx_en_i;
   logic [31:0] rx_data_o;
   logic        rx_err_o;
   logic        rx_valid_o;
   logic        rx_ready_i;
   logic        err_o;
   logic        busy_o;
   logic [15:0] wr_cnt_o;
   logic [15:0] rd_cnt_o;

   int total = 0;
   int bad   = 0;

   // Device model state
   bit          resp_q[$];
   logic [2:0]  op_q[$];
   logic [31:0] rxd_q[$];
   bit          hold_resp;
   bit          rd_err_inj;
   bit          tx_stream;
   int          rd_idx;
   int          err_cnt;

   always #5 clk_i = ~clk_i;

   spi_host_window_initiator dut (
      .clk_i(clk_i), .rst_i(rst_i), .tl_o(tl_o), .tl_i(tl_i),
      .tx_data_i(tx_data_i), .tx_be_i(tx_be_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
      .rx_en_i(rx_en_i), .rx_data_o(rx_data_o), .rx_err_o(rx_err_o), .rx_valid_o(rx_valid_o),
      .rx_ready_i(rx_ready_i), .err_o(err_o), .busy_o(busy_o),
      .wr_cnt_o(wr_cnt_o), .rd_cnt_o(rd_cnt_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_logs();
      op_q.delete();
      rxd_q.delete();
      err_cnt = 0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   // Runs n cycles: answers accepted requests one cycle later, logs opcodes, pops and err pulses
   task automatic run_dev(input int n);
      for (int i = 0; i < n; i++) begin
         bit fire;
         bit fsrc;
         bit txf;
         bit src;
         tl_i.d_valid  = 1'b0;
         tl_i.d_error  = 1'b0;
         tl_i.d_data   = '0;
         tl_i.d_source = '0;
         tl_i.d_opcode = '0;
         if (!hold_resp && resp_q.size() > 0) begin
            src = resp_q.pop_front();
            tl_i.d_valid  = 1'b1;
            tl_i.d_source = {7'd0, src};
            tl_i.d_opcode = src ? OpAccessAckData : OpAccessAck;
            if (src) begin
               tl_i.d_error = rd_err_inj;
               tl_i.d_data  = rd_err_inj ? 32'hBAD0_BAD0 : (32'hD000_0000 + 32'(rd_idx));
               rd_idx++;
            end
         end
         tx_valid_i = tx_stream;
         #1;
         fire = tl_o.a_valid & tl_i.a_ready;
         fsrc = tl_o.a_source[0];
         if (fire) op_q.push_back(tl_o.a_opcode);
         if (rx_valid_o & rx_ready_i) rxd_q.push_back(rx_data_o);
         txf = tx_valid_i & tx_ready_o;
         tick();
         if (fire) resp_q.push_back(fsrc);
         if (txf) tx_data_i = tx_data_i + 32'd1;
         if (err_o) err_cnt++;
      end
      tx_valid_i   = 1'b0;
      tl_i.d_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (tl_o.a_valid !== 1'b0) begin bad++; $display("FAIL reset_a_valid got=%b exp=0", tl_o.a_valid); end
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
      total++; if (rx_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid_o); end
      total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_o); end
      total++; if (tx_ready_o !== 1'b1) begin bad++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready_o); end
      total++; if (wr_cnt_o !== 16'd0 || rd_cnt_o !== 16'd0) begin
         bad++; $display("FAIL reset_cnt got wr=%0d rd=%0d exp 0/0", wr_cnt_o, rd_cnt_o);
      end
   endtask

   task automatic test_write_full();
      clear_logs();
      tl_i.a_ready = 1'b1;
      tx_data_i    = 32'hA5A5_0001;
      tx_be_i      = 4'hF;
      tx_valid_i   = 1'b1;
      #1;
      total++; if (tx_ready_o !== 1'b1) begin bad++; $display("FAIL wr_tx_ready got=%b exp=1", tx_ready_o); end
      tick();
      tx_valid_i = 1'b0;
      total++; if (tl_o.a_valid !== 1'b1 || tl_o.a_opcode !== OpPutFullData) begin
         bad++; $display("FAIL wr_a_op got v=%b op=%0d exp v=1 op=0", tl_o.a_valid, tl_o.a_opcode);
      end
      total++; if (tl_o.a_address !== 32'h24 || tl_o.a_mask !== 4'hF || tl_o.a_data !== 32'hA5A5_0001) begin
         bad++; $display("FAIL wr_a_fields got addr=%h mask=%h data=%h exp 24/f/a5a50001",
                         tl_o.a_address, tl_o.a_mask, tl_o.a_data);
      end
      total++; if (tl_o.a_size !== 2'd2 || tl_o.a_source[0] !== 1'b0) begin
         bad++; $display("FAIL wr_a_size_src got size=%0d src=%b exp 2/0", tl_o.a_size, tl_o.a_source[0]);
      end
      run_dev(4);
      total++; if (busy_o !== 1'b0 || op_q.size() != 1) begin
         bad++; $display("FAIL wr_done got busy=%b reqs=%0d exp 0/1", busy_o, op_q.size());
      end
      total++; if (err_cnt != 0) begin bad++; $display("FAIL wr_err got=%0d exp=0", err_cnt); end
      total++; if (wr_cnt_o !== (PerfEn ? 16'd1 : 16'd0)) begin
         bad++; $display("FAIL wr_cnt got=%0d exp=%0d", wr_cnt_o, PerfEn ? 1 : 0);
      end
   endtask

   task automatic test_partial_stall();
      clear_logs();
      tl_i.a_ready = 1'b0;
      tx_data_i    = 32'h1234_5678;
      tx_be_i      = 4'h3;
      tx_valid_i   = 1'b1;
      tick();
      tx_valid_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         total++;
         if (tl_o.a_valid !== 1'b1 || tl_o.a_opcode !== OpPutPartialData || tl_o.a_mask !== 4'h3 ||
             tl_o.a_data !== 32'h1234_5678 || tl_o.a_address !== 32'h24 || tx_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold[%0d] got v=%b op=%0d mask=%h data=%h addr=%h rdy=%b exp 1/1/3/12345678/24/0",
                     i, tl_o.a_valid, tl_o.a_opcode, tl_o.a_mask, tl_o.a_data, tl_o.a_address, tx_ready_o);
         end
         tick();
      end
      tl_i.a_ready = 1'b1;
      run_dev(5);
      total++; if (op_q.size() != 1) begin bad++; $display("FAIL stall_once got=%0d exp=1", op_q.size()); end
      else begin
         total++; if (op_q[0] !== OpPutPartialData) begin bad++; $display("FAIL stall_op got=%0d exp=1", op_q[0]); end
      end
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL stall_busy got=%b exp=0", busy_o); end
   endtask

   task automatic test_rx_backpressure();
      int n_gets;
      clear_logs();
      tl_i.a_ready = 1'b1;
      rx_ready_i   = 1'b0;
      rx_en_i      = 1'b1;
      rd_idx       = 0;
      run_dev(12);
      total++; if (op_q.size() != 2) begin bad++; $display("FAIL rx_bp_gets got=%0d exp=2", op_q.size()); end
      total++; if (rx_valid_o !== 1'b1 || rx_data_o !== 32'hD000_0000 || rx_err_o !== 1'b0) begin
         bad++; $display("FAIL rx_bp_head got v=%b d=%h e=%b exp 1/d0000000/0", rx_valid_o, rx_data_o, rx_err_o);
      end
      rx_ready_i = 1'b1;
      run_dev(12);
      n_gets = op_q.size();
      total++; if (n_gets <= 2) begin bad++; $display("FAIL rx_resume got=%0d exp>2", n_gets); end
      rx_en_i = 1'b0;
      run_dev(10);
      total++; if (rxd_q.size() < 2 || rxd_q[0] !== 32'hD000_0000 || rxd_q[1] !== 32'hD000_0001) begin
         bad++; $display("FAIL rx_order got n=%0d exp first d0000000,d0000001", rxd_q.size());
      end
      total++; if (rxd_q.size() != op_q.size()) begin
         bad++; $display("FAIL rx_count got=%0d exp=%0d", rxd_q.size(), op_q.size());
      end
      total++; if (busy_o !== 1'b0 || rx_valid_o !== 1'b0) begin
         bad++; $display("FAIL rx_drain got busy=%b v=%b exp 0/0", busy_o, rx_valid_o);
      end
      rx_ready_i = 1'b0;
   endtask

   task automatic test_alternate();
      logic [2:0] exp_op;
      do_reset();
      clear_logs();
      tl_i.a_ready = 1'b1;
      rx_ready_i   = 1'b1;
      rx_en_i      = 1'b1;
      tx_be_i      = 4'hF;
      tx_data_i    = 32'h0000_1000;
      tx_stream    = 1'b1;
      run_dev(24);
      tx_stream = 1'b0;
      rx_en_i   = 1'b0;
      run_dev(10);
      total++; if (op_q.size() < 6) begin bad++; $display("FAIL alt_count got=%0d exp>=6", op_q.size()); end
      for (int i = 0; i < 6 && i < op_q.size(); i++) begin
         exp_op = (i % 2 == 0) ? OpPutFullData : OpGet;
         total++; if (op_q[i] !== exp_op) begin
            bad++; $display("FAIL alt_op[%0d] got=%0d exp=%0d", i, op_q[i], exp_op);
         end
      end
      rx_ready_i = 1'b0;
   endtask

   task automatic test_rd_error();
      do_reset();
      clear_logs();
      tl_i.a_ready = 1'b1;
      rx_ready_i   = 1'b0;
      rd_err_inj   = 1'b1;
      rx_en_i      = 1'b1;
      run_dev(1);
      rx_en_i = 1'b0;
      run_dev(6);
      rd_err_inj = 1'b0;
      total++; if (op_q.size() != 1) begin bad++; $display("FAIL rderr_gets got=%0d exp=1", op_q.size()); end
      total++; if (rx_valid_o !== 1'b1 || rx_err_o !== 1'b1 || rx_data_o !== 32'd0) begin
         bad++; $display("FAIL rderr_word got v=%b e=%b d=%h exp 1/1/0", rx_valid_o, rx_err_o, rx_data_o);
      end
      total++; if (err_cnt != 1) begin bad++; $display("FAIL rderr_pulse got=%0d exp=1", err_cnt); end
      rx_ready_i = 1'b1;
      tick();
      rx_ready_i = 1'b0;
      total++; if (rx_valid_o !== 1'b0) begin bad++; $display("FAIL rderr_pop got=%b exp=0", rx_valid_o); end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      clear_logs();
      resp_q.delete();
      tl_i.a_ready = 1'b1;
      rx_ready_i   = 1'b0;
      hold_resp    = 1'b1;
      rx_en_i      = 1'b1;
      run_dev(8);
      rx_en_i = 1'b0;
      total++; if (op_q.size() != 2 || busy_o !== 1'b1) begin
         bad++; $display("FAIL rstmid_inflight got reqs=%0d busy=%b exp 2/1", op_q.size(), busy_o);
      end
      do_reset();
      hold_resp = 1'b0;
      err_cnt   = 0;
      run_dev(6);
      total++; if (err_cnt != 2) begin bad++; $display("FAIL rstmid_err got=%0d exp=2", err_cnt); end
      total++; if (busy_o !== 1'b0 || rx_valid_o !== 1'b0) begin
         bad++; $display("FAIL rstmid_idle got busy=%b v=%b exp 0/0", busy_o, rx_valid_o);
      end
      total++; if (rd_cnt_o !== 16'd0) begin bad++; $display("FAIL rstmid_rdcnt got=%0d exp=0", rd_cnt_o); end
   endtask

   initial begin
      tl_i       = '0;
      tx_data_i  = '0;
      tx_be_i    = '0;
      tx_valid_i = 1'b0;
      rx_en_i    = 1'b0;
      rx_ready_i = 1'b0;
      hold_resp  = 1'b0;
      rd_err_inj = 1'b0;
      tx_stream  = 1'b0;
      rd_idx     = 0;
      err_cnt    = 0;
      rst_i      = 1'b1;
      test_reset();
      test_write_full();
      test_partial_stall();
      test_rx_backpressure();
      test_alternate();
      test_rd_error();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
